pipeline_ctrl: RTL

Central stall/flush sequencer for the 5-stage core (fetch, decode, exec, mem, reg-write). It combines three events into per-stage register enables and flushes, with priority mem-wait > branch > load-use:
- data-memory wait freezes the whole pipe;
- a taken branch resolved in exec flushes the wrong-path instructions;
- a load-use dependency between decode and exec inserts bubbles.

It also keeps saturating stall and flush counters for performance monitoring.

---
 rtl/pipeline_ctrl_pkg.sv | 29 ++
 rtl/pipeline_ctrl_hazard_detect.sv | 23 ++
 rtl/pipeline_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned REM_W     = 2;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      FLUSH    = 2'd2
   } ctrl_state_t;

   typedef struct packed {
      logic pc;
      logic if_id;
      logic id_ex;
      logic ex_mem;
      logic mem_wb;
   } stage_en_t;

   // Load-use bubble: hold PC and IF/ID, let the older stages drain.
   localparam stage_en_t STAGE_EN_LU = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b1,
                                         ex_mem: 1'b1, mem_wb: 1'b1};

   function automatic stage_en_t stage_en_fill(input logic v);
      return '{pc: v, if_id: v, id_ex: v, ex_mem: v, mem_wb: v};
   endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator between the decode sources and the exec load destination.
module hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] dec_rs1,
   input  logic [REG_IDX_W-1:0] dec_rs2,
   input  logic                 dec_rs1_used,
   input  logic                 dec_rs2_used,
   input  logic [REG_IDX_W-1:0] exe_rd,
   input  logic                 exe_load,
   output logic                 lu_hit_c
);

   logic rs1_hit_c;
   logic rs2_hit_c;

   assign rs1_hit_c = dec_rs1_used & (dec_rs1 == exe_rd);
   assign rs2_hit_c = dec_rs2_used & (dec_rs2 == exe_rd);

   // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
   assign lu_hit_c  = exe_load & (exe_rd != '0) & (rs1_hit_c | rs2_hit_c);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: mem-wait > branch > load-use,
// with saturating stall and flush performance counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_DEPTH = 2,
   parameter int unsigned LOAD_STALL  = 1,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 branch_en_i,
   input  logic [REG_IDX_W-1:0] dec_rs1_i,
   input  logic [REG_IDX_W-1:0] dec_rs2_i,
   input  logic                 dec_rs1_used_i,
   input  logic                 dec_rs2_used_i,
   input  logic [REG_IDX_W-1:0] exe_rd_i,
   input  logic                 exe_load_i,
   input  logic                 mem_req_i,
   input  logic                 mem_ready_i,
   output logic                 pc_en_o,
   output logic                 if_id_en_o,
   output logic                 id_ex_en_o,
   output logic                 ex_mem_en_o,
   output logic                 mem_wb_en_o,
   output logic                 if_id_flush_o,
   output logic                 id_ex_flush_o,
   output logic [1:0]           state_o,
   output logic [CNT_W-1:0]     stall_cnt_o,
   output logic [CNT_W-1:0]     flush_cnt_o
);

   // Remaining-cycle preloads; the event cycle itself is the first of the sequence.
   localparam logic [REM_W-1:0] FLUSH_INIT =
      (FLUSH_DEPTH > 1) ? REM_W'(FLUSH_DEPTH - 2) : '0;
   localparam logic [REM_W-1:0] LU_INIT =
      (LOAD_STALL > 1) ? REM_W'(LOAD_STALL - 2) : '0;

   ctrl_state_t       state_q;
   ctrl_state_t       state_d;
   logic [REM_W-1:0]  rem_q;
   logic [REM_W-1:0]  rem_d;
   stage_en_t         en_c;
   logic              if_id_flush_c;
   logic              id_ex_flush_c;
   logic              lu_hit_c;
   logic              mem_wait_c;
   logic              flush_inc_c;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic [CNT_W-1:0]  flush_cnt_q;

   hazard_detect u_hazard_detect (
      .dec_rs1      (dec_rs1_i),
      .dec_rs2      (dec_rs2_i),
      .dec_rs1_used (dec_rs1_used_i),
      .dec_rs2_used (dec_rs2_used_i),
      .exe_rd       (exe_rd_i),
      .exe_load     (exe_load_i),
      .lu_hit_c     (lu_hit_c)
   );

   assign mem_wait_c  = mem_req_i & ~mem_ready_i;
   assign flush_inc_c = branch_en_i & ~mem_wait_c;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= RUN;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   // Next state and zero-latency stage controls.
   always_comb begin
      state_d       = state_q;
      rem_d         = rem_q;
      en_c          = stage_en_fill(1'b1);
      if_id_flush_c = 1'b0;
      id_ex_flush_c = 1'b0;

      if (reset_i) begin
         en_c          = stage_en_fill(1'b0);
         if_id_flush_c = 1'b1;
         id_ex_flush_c = 1'b1;
         state_d       = RUN;
         rem_d         = '0;
      end else if (mem_wait_c) begin
         en_c = stage_en_fill(1'b0);
      end else if (branch_en_i) begin
         if_id_flush_c = 1'b1;
         id_ex_flush_c = 1'b1;
         if (FLUSH_DEPTH > 1) begin
            state_d = FLUSH;
            rem_d   = FLUSH_INIT;
         end else begin
            state_d = RUN;
            rem_d   = '0;
         end
      end else begin
         case (state_q)
            RUN: begin
               if (lu_hit_c) begin
                  en_c          = STAGE_EN_LU;
                  id_ex_flush_c = 1'b1;
                  if (LOAD_STALL > 1) begin
                     state_d = LU_STALL;
                     rem_d   = LU_INIT;
                  end
               end
            end
            LU_STALL: begin
               en_c          = STAGE_EN_LU;
               id_ex_flush_c = 1'b1;
               if (rem_q == '0) state_d = RUN;
               else             rem_d   = rem_q - REM_W'(1);
            end
            FLUSH: begin
               // Decode holds a bubble here, so any lu_hit is spurious.
               if_id_flush_c = 1'b1;
               if (rem_q == '0) state_d = RUN;
               else             rem_d   = rem_q - REM_W'(1);
            end
            default: begin
               state_d = RUN;
               rem_d   = '0;
            end
         endcase
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!en_c.pc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_inc_c && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign pc_en_o       = en_c.pc;
   assign if_id_en_o    = en_c.if_id;
   assign id_ex_en_o    = en_c.id_ex;
   assign ex_mem_en_o   = en_c.ex_mem;
   assign mem_wb_en_o   = en_c.mem_wb;
   assign if_id_flush_o = if_id_flush_c;
   assign id_ex_flush_o = id_ex_flush_c;
   assign state_o       = reset_i ? RUN : state_q;
   assign stall_cnt_o   = reset_i ? '0 : stall_cnt_q;
   assign flush_cnt_o   = reset_i ? '0 : flush_cnt_q;

endmodule
